// File: rtl/des_ct_serial_tx.sv
// des_ct_serial_tx: buffers 64-bit DES ciphertext words in a small FIFO and
// serializes them MSB-byte first onto a UART-style line (8N1, or 8E1 with parity).
// Ports: clk; reset (async, active-low); ct_valid/ct_data/ct_ready word input
// handshake; tx serial line (idle high); tx_busy frame in progress;
// buffer_full/buffer_empty FIFO status flags.
// Optional: define DES_TX_PARITY_EN to append an even-parity bit to each byte.
module des_ct_serial_tx #(
    parameter int fifo_depth   = 4,
    parameter int fifo_width   = 64,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ct_valid,
    input  logic [fifo_width-1:0] ct_data,
    output logic                  ct_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  buffer_full,
    output logic                  buffer_empty
);

    localparam int PW = $clog2(fifo_depth);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH     = (PW + 1)'(fifo_depth);

`ifdef DES_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    logic [fifo_width-1:0] r_mem [fifo_depth];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_count;
    logic [PW:0]           w_count_next;
    logic                  r_full;
    logic                  r_empty;

    state_t                r_state;
    state_t                w_state_next;
    logic [BW-1:0]         r_baud;
    logic [2:0]            r_bit_idx;
    logic [2:0]            r_byte_idx;
    logic [fifo_width-1:0] r_shift;
    logic                  r_tx;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_next_byte;
    logic                  w_baud_done;
    logic                  w_tx_next;
    logic [7:0]            w_byte;

    assign ct_ready     = !r_full;
    assign buffer_full  = r_full;
    assign buffer_empty = r_empty;
    assign tx           = r_tx;
    assign tx_busy      = (r_state != S_IDLE);

    assign w_push      = ct_valid && !r_full;
    assign w_baud_done = (r_baud == BAUD_LAST);
    // The byte on the wire is always the top byte of the shift register.
    assign w_byte      = r_shift[fifo_width-1 -: 8];

    // ---------------- FIFO ----------------
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ct_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == DEPTH);
            r_empty <= (w_count_next == '0);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_next_byte  = 1'b0;
        w_tx_next    = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = w_byte[r_bit_idx];
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef DES_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef DES_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = ^w_byte;
                if (w_baud_done) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    if (r_byte_idx != 3'd7) begin
                        w_next_byte  = 1'b1;
                        w_state_next = S_START;
                    end else if (!r_empty) begin
                        // Chain straight into the next word, no idle gap.
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    // tx is registered so the pin never glitches; it trails the state by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if ((r_state == S_IDLE) || (w_state_next != r_state) || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_baud_done) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_pop) begin
                r_shift    <= r_mem[r_rd_ptr];
                r_byte_idx <= '0;
            end else if (w_next_byte) begin
                r_shift    <= {r_shift[fifo_width-9:0], 8'h00};
                r_byte_idx <= r_byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_des_ct_serial_tx.sv
// tb_des_ct_serial_tx: directed + randomized bench for des_ct_serial_tx.
// Records tx each cycle and decodes UART frames against an expected word list.
module tb_des_ct_serial_tx;

    localparam int CPB = 4;
`ifdef DES_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME = (10 + NPAR) * CPB;
    localparam int WORD  = 8 * FRAME;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ct_valid = 1'b0;
    logic [63:0] ct_data = '0;
    logic        ct_ready;
    logic        tx;
    logic        tx_busy;
    logic        buffer_full;
    logic        buffer_empty;

    int n_vec = 0;
    int n_err = 0;

    logic        txh[$];
    logic        bsyh[$];
    logic [7:0]  rx_b[$];
    int          rx_s[$];
    logic        rx_p[$];
    logic        rx_e[$];
    logic [63:0] exp_w[$];

    always #5 clk = ~clk;

    des_ct_serial_tx #(
        .fifo_depth  (4),
        .fifo_width  (64),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ct_valid    (ct_valid),
        .ct_data     (ct_data),
        .ct_ready    (ct_ready),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .buffer_full (buffer_full),
        .buffer_empty(buffer_empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        txh.push_back(tx);
        bsyh.push_back(tx_busy);
    endtask

    task automatic clear_hist();
        txh.delete();
        bsyh.delete();
        exp_w.delete();
    endtask

    task automatic push_word(input logic [63:0] w);
        ct_valid = 1'b1;
        ct_data  = w;
        tick();
        ct_valid = 1'b0;
        ct_data  = {$urandom, $urandom};
        exp_w.push_back(w);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((tx_busy || !buffer_empty) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_busy", {63'd0, tx_busy}, 64'd0);
        repeat (4) tick();
    endtask

    function automatic int busy_count();
        int c;
        c = 0;
        foreach (bsyh[i]) if (bsyh[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int low_count();
        int c;
        c = 0;
        foreach (txh[i]) if (txh[i] !== 1'b1) c++;
        return c;
    endfunction

    // Frame decoder: find the falling edge, then sample each bit at mid-bit.
    task automatic decode();
        int i;
        int m;
        logic [7:0] b;
        rx_b.delete();
        rx_s.delete();
        rx_p.delete();
        rx_e.delete();
        i = 0;
        while (i < txh.size()) begin
            if (txh[i] === 1'b0) begin
                m = i + CPB / 2;
                if (m + (9 + NPAR) * CPB >= txh.size()) break;
                for (int k = 0; k < 8; k++) b[k] = txh[m + CPB * (k + 1)];
                rx_b.push_back(b);
                rx_s.push_back(i);
                rx_p.push_back(txh[m + 9 * CPB]);
                rx_e.push_back(txh[m + (9 + NPAR) * CPB]);
                i = m + (9 + NPAR) * CPB + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_words(input string tag);
        logic [63:0] w;
        logic [7:0]  e;
        int          n;
        decode();
        chk({tag, "_nbytes"}, 64'(rx_b.size()), 64'(8 * exp_w.size()));
        n = (rx_b.size() < 8 * exp_w.size()) ? rx_b.size() : 8 * exp_w.size();
        if (n > 0) chk({tag, "_first_start"}, 64'(rx_s[0]), 64'd2);
        for (int j = 0; j < n; j++) begin
            w = exp_w[j / 8];
            w = w >> (56 - 8 * (j % 8));
            e = w[7:0];
            chk($sformatf("%s_byte%0d", tag, j), {56'd0, rx_b[j]}, {56'd0, e});
            chk($sformatf("%s_stop%0d", tag, j), {63'd0, rx_e[j]}, 64'd1);
`ifdef DES_TX_PARITY_EN
            chk($sformatf("%s_par%0d", tag, j), {63'd0, rx_p[j]}, {63'd0, ^e});
`endif
            if (j > 0)
                chk($sformatf("%s_gap%0d", tag, j), 64'(rx_s[j] - rx_s[j-1]), 64'(FRAME));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx"},    {63'd0, tx},           64'd1);
        chk({tag, "_busy"},  {63'd0, tx_busy},      64'd0);
        chk({tag, "_empty"}, {63'd0, buffer_empty}, 64'd1);
        chk({tag, "_full"},  {63'd0, buffer_full},  64'd0);
        chk({tag, "_ready"}, {63'd0, ct_ready},     64'd1);
    endtask

    initial begin
        logic [63:0] w [6];
        logic [63:0] x;
        int          k;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b1;
        repeat (2) tick();

        // Single word, fixed pattern
        clear_hist();
        push_word(64'h0123456789ABCDEF);
        repeat (WORD + 20) tick();
        chk("t1_tx_n1", {63'd0, txh[1]}, 64'd1);
        chk("t1_tx_n2", {63'd0, txh[2]}, 64'd0);
        chk("t1_busy_cycles", 64'(busy_count()), 64'(WORD));
        chk("t1_empty_after", {63'd0, buffer_empty}, 64'd1);
        check_words("t1");

        // Burst of six words into a depth-4 FIFO
        clear_hist();
        for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_ready%0d", i), {63'd0, ct_ready}, 64'd1);
            push_word(w[i]);
        end
        chk("t2_full", {63'd0, buffer_full}, 64'd1);
        chk("t2_ready_low", {63'd0, ct_ready}, 64'd0);
        ct_valid = 1'b1;
        ct_data  = w[5];
        k = 0;
        while (!ct_ready && k < 2 * WORD) begin
            tick();
            k++;
        end
        chk("t2_w5_ready_at", 64'(txh.size() - 1), 64'(WORD + 1));
        tick();
        ct_valid = 1'b0;
        exp_w.push_back(w[5]);
        drain(7 * WORD);
        check_words("t2");

        // Push on the same edge as the end-of-word pop, count 2
        clear_hist();
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom});
        while (txh.size() < 1 + WORD) tick();
        chk("t3_pre_empty", {63'd0, buffer_empty}, 64'd0);
        chk("t3_pre_full",  {63'd0, buffer_full},  64'd0);
        push_word({$urandom, $urandom});
        chk("t3_post_empty", {63'd0, buffer_empty}, 64'd0);
        chk("t3_post_full",  {63'd0, buffer_full},  64'd0);
        drain(5 * WORD);
        check_words("t3");

        // Reset during data bit 3 of byte 2 with two words buffered
        clear_hist();
        x = {$urandom, $urandom};
        push_word(x);
        push_word({$urandom, $urandom});
        push_word({$urandom, $urandom});
        while (txh.size() < 2 + 2 * FRAME + 4 * CPB + 2) tick();
        chk("t4_bit3", {63'd0, tx}, {63'd0, x[43]});
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state("t4_rst");
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        clear_hist();
        repeat (3 * FRAME) tick();
        chk("t4_quiet_tx", 64'(low_count()), 64'd0);
        chk("t4_quiet_busy", 64'(busy_count()), 64'd0);
        chk("t4_quiet_empty", {63'd0, buffer_empty}, 64'd1);
        clear_hist();
        push_word({$urandom, $urandom});
        repeat (WORD + 20) tick();
        check_words("t4");

        // Parity-sensitive word
        clear_hist();
        push_word(64'h0700000000000000);
        repeat (WORD + 20) tick();
        chk("t5_busy_cycles", 64'(busy_count()), 64'(WORD));
        check_words("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
